// File: rtl/riego_pkg.sv
// riego_pkg: shared states, per-plant thresholds and stop-level helpers for the irrigation controller.
package riego_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RIEGO = 2'd1, ESPERA = 2'd2, FALLO = 2'd3} estado_t;
  localparam logic [11:0] UMBRAL [8] = '{12'd1200, 12'd1500, 12'd1800, 12'd2100,
                                        12'd2400, 12'd2700, 12'd3000, 12'd3300};
  function automatic logic [11:0] umbral_de(input logic [3:0] tipo);
    return tipo[3] ? 12'd0 : UMBRAL[tipo[2:0]];
  endfunction
  function automatic logic [11:0] tope(input logic [11:0] u, input logic [11:0] h);
    logic [12:0] s;
    s = {1'b0, u} + {1'b0, h};
    return s[12] ? 12'hfff : s[11:0];
  endfunction
endpackage

// File: rtl/pulso_seg.sv
// pulso_seg: CLK_HZ prescaler giving a one-cycle tick per second, restartable by clr.
module pulso_seg #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_HZ - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/riego_ctrl.sv
// riego_ctrl: pump controller with timed watering, soak and fault lockout driven by decoded humidity frames.
module riego_ctrl
  import riego_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int RIEGO_MAX_S = 30,
  parameter int ESPERA_S    = 60,
  parameter int DATO_TO_S   = 5,
  parameter int HIST        = 100,
  parameter int MAX_REINT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        listo,
  input  logic [11:0] humedad,
  input  logic [3:0]  tipoPlanta,
  input  logic        MODbomba,
  output logic        activarB,
  output logic        regar,
  output logic [1:0]  estado,
  output logic [1:0]  reintentos
);
  localparam int GAP = DATO_TO_S * CLK_HZ;
  localparam int GW  = $clog2(GAP + 1);
  estado_t st, st_n;
  logic [7:0] seg;
  logic [GW-1:0] gap;
  logic [11:0] umb, umb_n, u_in, stop;
  logic [1:0] rei, rei_n, rei_inc;
  logic tick, clr, regar_n, fin_max, fin_esp, fin_dato;
  pulso_seg #(.CLK_HZ(CLK_HZ)) u_seg (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  assign u_in     = umbral_de(tipoPlanta);
  assign stop     = tope(umb, 12'(HIST));
  assign clr      = st_n != st;
  assign fin_max  = tick && seg == 8'(RIEGO_MAX_S - 1);
  assign fin_esp  = tick && seg == 8'(ESPERA_S - 1);
  assign fin_dato = !listo && gap == GW'(GAP - 1);
  assign rei_inc  = rei == 2'(MAX_REINT) ? rei : rei + 2'd1;
  assign estado   = st;
  assign reintentos = rei;
  always_comb begin
    st_n = st;
    umb_n = umb;
    rei_n = rei;
    regar_n = regar;
    unique case (st)
      IDLE:
        if (listo) begin
          if (humedad < u_in) begin
            if (MODbomba) begin
              st_n = RIEGO;
              umb_n = u_in;
            end else regar_n = 1'b1;
          end else regar_n = 1'b0;
        end
      RIEGO:
        if (!MODbomba) st_n = IDLE;
        else if (listo && humedad >= stop) begin
          st_n = ESPERA;
          rei_n = '0;
        end else if (fin_max || fin_dato) begin
          rei_n = rei_inc;
          st_n = rei_inc == 2'(MAX_REINT) ? FALLO : ESPERA;
        end
      ESPERA: st_n = fin_esp ? IDLE : ESPERA;
      FALLO:  regar_n = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      umb <= '0;
      rei <= '0;
      activarB <= 1'b0;
      regar <= 1'b0;
      seg <= '0;
      gap <= '0;
    end else begin
      st <= st_n;
      umb <= umb_n;
      rei <= rei_n;
      activarB <= st_n == RIEGO;
      regar <= regar_n || st_n == FALLO;
      seg <= clr ? '0 : tick ? seg + 8'd1 : seg;
      gap <= (clr || listo) ? '0 : gap + 1'b1;
    end
endmodule

// File: tb/tb_riego_ctrl.sv
// tb_riego_ctrl: directed checks of watering, timeout, fault, no-pump and bound cases.
module tb_riego_ctrl;
  logic clk = 0, rst = 1, listo = 0, MODbomba = 0;
  logic [11:0] humedad = 0;
  logic [3:0] tipoPlanta = 0;
  logic activarB, regar;
  logic [1:0] estado, reintentos;
  int checks = 0, errors = 0;
  riego_ctrl #(.CLK_HZ(10), .RIEGO_MAX_S(3), .ESPERA_S(2), .DATO_TO_S(2)) dut (
    .clk(clk), .rst(rst), .listo(listo), .humedad(humedad), .tipoPlanta(tipoPlanta),
    .MODbomba(MODbomba), .activarB(activarB), .regar(regar), .estado(estado), .reintentos(reintentos));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int h, input int t);
    listo = 1; humedad = 12'(h); tipoPlanta = 4'(t);
    tk(1);
    listo = 0;
  endtask
  task automatic timeout_try(input int exp_rei);
    pulse(1000, 0);
    chk("to_riego", estado, 1);
    tk(9); pulse(1000, 0);
    tk(9); pulse(1000, 0);
    tk(9);
    chk("to_still", estado, 1);
    tk(1);
    chk("to_rei", reintentos, exp_rei);
  endtask
  initial begin
    #2;
    chk("rst_act", activarB, 0); chk("rst_regar", regar, 0);
    chk("rst_est", estado, 0); chk("rst_rei", reintentos, 0);
    tk(1); rst = 0; MODbomba = 1;
    // success path
    pulse(1000, 0);
    chk("ok_est", estado, 1); chk("ok_act", activarB, 1);
    pulse(1300, 0);
    chk("ok_esp", estado, 2); chk("ok_act0", activarB, 0); chk("ok_rei", reintentos, 0);
    tk(19); chk("esp_19", estado, 2);
    tk(1);  chk("esp_20", estado, 0);
    // no pump
    MODbomba = 0;
    pulse(500, 0);
    chk("np_regar", regar, 1); chk("np_act", activarB, 0); chk("np_est", estado, 0);
    pulse(2000, 0);
    chk("np_clr", regar, 0);
    // repeated timeouts into FALLO
    MODbomba = 1;
    timeout_try(1); chk("t1_est", estado, 2);
    tk(20);
    timeout_try(2); chk("t2_est", estado, 2);
    tk(20);
    timeout_try(3);
    chk("f_est", estado, 3); chk("f_regar", regar, 1); chk("f_act", activarB, 0);
    pulse(2000, 0); tk(40);
    chk("f_hold", estado, 3);
    rst = 1; #1;
    chk("f_rst_est", estado, 0); chk("f_rst_rei", reintentos, 0); chk("f_rst_regar", regar, 0);
    tk(1); rst = 0;
    // stale data
    pulse(1000, 0);
    tk(19); chk("st_19", estado, 1);
    tk(1);  chk("st_20", estado, 2); chk("st_rei", reintentos, 1);
    tk(20); chk("st_idle", estado, 0);
    // pump removed mid-watering
    pulse(1000, 0);
    tk(3); MODbomba = 0;
    tk(1);
    chk("pr_act", activarB, 0); chk("pr_est", estado, 0); chk("pr_rei", reintentos, 1);
    // success coinciding with timeout
    MODbomba = 1;
    pulse(1000, 0);
    tk(9); pulse(1000, 0);
    tk(19); pulse(1300, 0);
    chk("co_est", estado, 2); chk("co_rei", reintentos, 0);
    tk(20); chk("co_idle", estado, 0);
    // bounds
    pulse(0, 12);
    chk("b12_est", estado, 0); chk("b12_act", activarB, 0);
    pulse(3290, 7);
    chk("b7_est", estado, 1);
    pulse(3399, 0);
    chk("b7_3399", estado, 1);
    pulse(3400, 0);
    chk("b7_3400", estado, 2);
    tk(20);
    pulse(1000, 0);
    tk(2); #2 rst = 1; #1;
    chk("ar_act", activarB, 0); chk("ar_est", estado, 0);
    chk("ar_regar", regar, 0); chk("ar_rei", reintentos, 0);
    tk(1); rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
